pipe_phy_status_ctrl: RTL and testbench

PHY-side command/status controller for a multi-lane PIPE link, run by the PHY bench model.
- Watches MAC-driven PowerDown, Rate and Width.
- Models the PHY completion latency for each change.
- Runs the PclkChangeOk/PclkChangeAck handshake on rate changes.
- Returns per-lane PhyStatus pulses, including the post-reset PhyStatus deassertion.
- Generalises lane count and all latencies.

---
 rtl/pipe_phy_pkg.sv | 22 ++
 rtl/pipe_lane_pd_compare.sv | 21 ++
 rtl/pipe_phy_status_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_phy_status_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_phy_pkg.sv
// Shared types and helpers for the PIPE PHY status controller.
// Controller state encoding, PIPE power-state codes and a latency max helper.
package pipe_phy_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT = 3'd0,
    IDLE       = 3'd1,
    CHANGE     = 3'd2,
    WAIT_ACK   = 3'd3,
    PULSE      = 3'd4
  } pipe_state_e;

  localparam logic [3:0] PD_P0  = 4'h0;
  localparam logic [3:0] PD_P0S = 4'h1;
  localparam logic [3:0] PD_P1  = 4'h2;
  localparam logic [3:0] PD_P2  = 4'h3;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_lane_pd_compare.sv
// Per-lane PowerDown comparator: flags lanes whose requested power state
// differs from the committed one, plus the OR of all lane flags.
module pipe_lane_pd_compare #(
  parameter int NUM_LANES = 16
) (
  input  logic [4*NUM_LANES-1:0] req_pd,
  input  logic [4*NUM_LANES-1:0] cur_pd,
  output logic [NUM_LANES-1:0]   lane_diff,
  output logic                   any_diff
);

  always_comb begin
    lane_diff = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_diff[i] = (req_pd[4*i +: 4] != cur_pd[4*i +: 4]);
    end
  end

  assign any_diff = |lane_diff;

endmodule

// File: rtl/pipe_phy_status_ctrl.sv
// PHY-side PIPE command/status controller: models rate/width/power-state change
// latency and returns PhyStatus pulses. Macro PIPE_PCLK_CHANGE_HANDSHAKE_EN adds the PclkChangeOk/Ack handshake.
module pipe_phy_status_ctrl
  import pipe_phy_pkg::*;
#(
  parameter int NUM_LANES          = 16,
  parameter int RESET_DONE_CYCLES  = 16,
  parameter int RATE_CHANGE_CYCLES = 8,
  parameter int PD_CHANGE_CYCLES   = 4
) (
  input  logic                   PCLK,
  input  logic                   Reset,
  input  logic [4*NUM_LANES-1:0] PowerDown,
  input  logic [3:0]             Rate,
  input  logic [1:0]             Width,
  input  logic                   PclkChangeAck,
  output logic [NUM_LANES-1:0]   PhyStatus,
  output logic                   PclkChangeOk,
  output logic [4*NUM_LANES-1:0] CurPowerDown,
  output logic [3:0]             CurRate,
  output logic [1:0]             CurWidth,
  output logic                   Busy,
  output pipe_state_e            state_dbg
);

  localparam int MAX_LAT = max_lat(max_lat(RESET_DONE_CYCLES, RATE_CHANGE_CYCLES),
                                   PD_CHANGE_CYCLES);
  localparam int CW = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] RESET_LOAD = CW'(RESET_DONE_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LOAD  = CW'(RATE_CHANGE_CYCLES - 1);
  localparam logic [CW-1:0] PD_LOAD    = CW'(PD_CHANGE_CYCLES - 1);
  localparam logic [CW-1:0] BOTH_LOAD  = CW'(max_lat(RATE_CHANGE_CYCLES, PD_CHANGE_CYCLES) - 1);

  pipe_state_e            state;
  logic [CW-1:0]          cnt;
  logic [4*NUM_LANES-1:0] tgt_pd;
  logic [3:0]             tgt_rate;
  logic [1:0]             tgt_width;
  logic [NUM_LANES-1:0]   lane_mask;
  logic                   rate_txn;

  logic [NUM_LANES-1:0]   pd_diff;
  logic                   pd_req;
  logic                   rate_req;
  logic                   enter_pulse;

  pipe_lane_pd_compare #(
    .NUM_LANES (NUM_LANES)
  ) u_pd_compare (
    .req_pd    (PowerDown),
    .cur_pd    (CurPowerDown),
    .lane_diff (pd_diff),
    .any_diff  (pd_req)
  );

  assign rate_req  = (Rate != CurRate) || (Width != CurWidth);
  assign state_dbg = state;

  // Commit point: targets land in Cur* on the same edge PhyStatus is raised.
  always_comb begin
    enter_pulse = 1'b0;
    if (state == CHANGE && cnt == '0) begin
      enter_pulse = 1'b1;
    end
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
    if (state == CHANGE && cnt == '0 && rate_txn) begin
      enter_pulse = 1'b0;
    end
    if (state == WAIT_ACK && PclkChangeAck) begin
      enter_pulse = 1'b1;
    end
`endif
  end

`ifndef PIPE_PCLK_CHANGE_HANDSHAKE_EN
  logic unused_inputs;
  assign unused_inputs = PclkChangeAck ^ rate_txn;
  assign PclkChangeOk  = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge Reset) begin
    if (!Reset) begin
      state        <= RESET_WAIT;
      cnt          <= RESET_LOAD;
      PhyStatus    <= '1;
      Busy         <= 1'b1;
      CurPowerDown <= {NUM_LANES{PD_P1}};
      CurRate      <= 4'h0;
      CurWidth     <= 2'h0;
      tgt_pd       <= '0;
      tgt_rate     <= 4'h0;
      tgt_width    <= 2'h0;
      lane_mask    <= '0;
      rate_txn     <= 1'b0;
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
      PclkChangeOk <= 1'b0;
`endif
    end else begin
      case (state)
        RESET_WAIT: begin
          if (cnt == '0) begin
            PhyStatus <= '0;
            Busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          if (rate_req || pd_req) begin
            tgt_pd    <= PowerDown;
            tgt_rate  <= Rate;
            tgt_width <= Width;
            rate_txn  <= rate_req;
            lane_mask <= rate_req ? {NUM_LANES{1'b1}} : pd_diff;
            Busy      <= 1'b1;
            state     <= CHANGE;
            if (rate_req && pd_req) begin
              cnt <= BOTH_LOAD;
            end else if (rate_req) begin
              cnt <= RATE_LOAD;
            end else begin
              cnt <= PD_LOAD;
            end
          end
        end
        CHANGE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
          else if (rate_txn) begin
            state        <= WAIT_ACK;
            PclkChangeOk <= 1'b1;
          end
`endif
        end
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
        WAIT_ACK: begin
          if (PclkChangeAck) begin
            PclkChangeOk <= 1'b0;
          end
        end
`endif
        PULSE: begin
          PhyStatus <= '0;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          PhyStatus <= '0;
          Busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase

      if (enter_pulse) begin
        state        <= PULSE;
        PhyStatus    <= lane_mask;
        CurPowerDown <= tgt_pd;
        CurRate      <= tgt_rate;
        CurWidth     <= tgt_width;
      end
    end
  end

endmodule

// File: tb/tb_pipe_phy_status_ctrl.sv
// Directed bench for pipe_phy_status_ctrl; adapts to PIPE_PCLK_CHANGE_HANDSHAKE_EN.
module tb_pipe_phy_status_ctrl;
  import pipe_phy_pkg::*;

  localparam int NL = 16;
`ifdef PIPE_PCLK_CHANGE_HANDSHAKE_EN
  localparam int HS = 1;
`else
  localparam int HS = 0;
`endif
  localparam logic [63:0] ALL_P1 = {16{4'h2}};
  localparam logic [63:0] ALL_P2 = {16{4'h3}};

  logic          clk;
  logic          rst_n;
  logic [63:0]   power_down;
  logic [3:0]    rate;
  logic [1:0]    width;
  logic          ack;
  logic [NL-1:0] phy_status;
  logic          ok;
  logic [63:0]   cur_pd;
  logic [3:0]    cur_rate;
  logic [1:0]    cur_width;
  logic          busy;
  pipe_state_e   state_dbg;

  int checks;
  int failures;

  pipe_phy_status_ctrl #(
    .NUM_LANES          (NL),
    .RESET_DONE_CYCLES  (16),
    .RATE_CHANGE_CYCLES (8),
    .PD_CHANGE_CYCLES   (4)
  ) dut (
    .PCLK          (clk),
    .Reset         (rst_n),
    .PowerDown     (power_down),
    .Rate          (rate),
    .Width         (width),
    .PclkChangeAck (ack),
    .PhyStatus     (phy_status),
    .PclkChangeOk  (ok),
    .CurPowerDown  (cur_pd),
    .CurRate       (cur_rate),
    .CurWidth      (cur_width),
    .Busy          (busy),
    .state_dbg     (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 2 time units past the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    power_down = ALL_P1;
    rate       = 4'h0;
    width      = 2'h0;
    ack        = 1'b0;

    // Reset values
    cyc(2);
    chk("rst_phystatus", 64'(phy_status), 64'hFFFF);
    chk("rst_busy", 64'(busy), 64'h1);
    chk("rst_ok", 64'(ok), 64'h0);
    chk("rst_cur_pd", cur_pd, ALL_P1);
    chk("rst_cur_rate", 64'(cur_rate), 64'h0);
    chk("rst_cur_width", 64'(cur_width), 64'h0);

    // PhyStatus held for 16 cycles after release, falls with Busy
    rst_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      chk("rstwait_phystatus", 64'(phy_status), 64'hFFFF);
      chk("rstwait_busy", 64'(busy), 64'h1);
    end
    cyc(1);
    chk("rstdone_phystatus", 64'(phy_status), 64'h0);
    chk("rstdone_busy", 64'(busy), 64'h0);
    chk("rstdone_state", 64'(state_dbg), 64'(IDLE));

    // Lane 3 only: P1 -> P0, 4-cycle latency, pulse in cycle 5
    power_down[15:12] = 4'h0;
    cyc(1);
    chk("pd_busy", 64'(busy), 64'h1);
    cyc(3);
    chk("pd_early_phystatus", 64'(phy_status), 64'h0);
    cyc(1);
    chk("pd_pulse", 64'(phy_status), 64'h0008);
    chk("pd_cur_pd", cur_pd, 64'h2222_2222_2222_0222);
    cyc(1);
    chk("pd_pulse_end", 64'(phy_status), 64'h0);
    chk("pd_busy_end", 64'(busy), 64'h0);

    // Rate 0 -> 1; a stray ack during CHANGE must be ignored
    rate = 4'h1;
    cyc(2);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("rate_stray_ack_busy", 64'(busy), 64'h1);
    chk("rate_stray_ack_phystatus", 64'(phy_status), 64'h0);
    cyc(5);
    chk("rate_c8_ok", 64'(ok), 64'h0);
    chk("rate_c8_phystatus", 64'(phy_status), 64'h0);
    cyc(1);
    if (HS == 1) begin
      chk("rate_ok_rise", 64'(ok), 64'h1);
      chk("rate_wait_phystatus", 64'(phy_status), 64'h0);
      chk("rate_wait_cur_rate", 64'(cur_rate), 64'h0);
      cyc(3);
      chk("rate_ok_held", 64'(ok), 64'h1);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      chk("rate_ok_clear", 64'(ok), 64'h0);
    end else begin
      chk("rate_ok_tied", 64'(ok), 64'h0);
    end
    chk("rate_pulse", 64'(phy_status), 64'hFFFF);
    chk("rate_cur_rate", 64'(cur_rate), 64'h1);
    cyc(1);
    chk("rate_pulse_end", 64'(phy_status), 64'h0);
    chk("rate_busy_end", 64'(busy), 64'h0);

    // Rate+width and all-lane PowerDown together: one 8-cycle transaction
    rate       = 4'h2;
    width      = 2'h1;
    power_down = ALL_P2;
    cyc(5);
    chk("both_c5_phystatus", 64'(phy_status), 64'h0);
    chk("both_c5_busy", 64'(busy), 64'h1);
    cyc(4);
    if (HS == 1) begin
      chk("both_ok", 64'(ok), 64'h1);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
    end
    chk("both_pulse", 64'(phy_status), 64'hFFFF);
    chk("both_cur_rate", 64'(cur_rate), 64'h2);
    chk("both_cur_width", 64'(cur_width), 64'h1);
    chk("both_cur_pd", cur_pd, ALL_P2);
    cyc(1);
    chk("both_pulse_end", 64'(phy_status), 64'h0);

    // Rate changed while busy: first commits 3, then a second txn commits 4
    rate = 4'h3;
    ack  = 1'b1;
    cyc(3);
    rate = 4'h4;
    chk("seq_busy", 64'(busy), 64'h1);
    cyc(6 + HS);
    chk("seq_pulse1", 64'(phy_status), 64'hFFFF);
    chk("seq_cur_rate1", 64'(cur_rate), 64'h3);
    cyc(1);
    chk("seq_gap_phystatus", 64'(phy_status), 64'h0);
    chk("seq_gap_busy", 64'(busy), 64'h0);
    cyc(1);
    chk("seq_busy2", 64'(busy), 64'h1);
    cyc(8 + HS);
    chk("seq_pulse2", 64'(phy_status), 64'hFFFF);
    chk("seq_cur_rate2", 64'(cur_rate), 64'h4);
    cyc(1);
    chk("seq_pulse2_end", 64'(phy_status), 64'h0);
    cyc(2);
    chk("seq_idle_busy", 64'(busy), 64'h0);
    ack = 1'b0;

    // Reset during WAIT_ACK (or at the pulse without the handshake)
    rate = 4'h5;
    cyc(9);
    if (HS == 1) begin
      chk("mid_ok", 64'(ok), 64'h1);
    end else begin
      chk("mid_pulse", 64'(phy_status), 64'hFFFF);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ok", 64'(ok), 64'h0);
    chk("mid_rst_phystatus", 64'(phy_status), 64'hFFFF);
    chk("mid_rst_cur_rate", 64'(cur_rate), 64'h0);
    chk("mid_rst_cur_width", 64'(cur_width), 64'h0);
    chk("mid_rst_cur_pd", cur_pd, ALL_P1);
    chk("mid_rst_busy", 64'(busy), 64'h1);
    rate       = 4'h0;
    width      = 2'h0;
    power_down = ALL_P1;
    cyc(1);
    rst_n = 1'b1;
    cyc(15);
    chk("rerst_c15_phystatus", 64'(phy_status), 64'hFFFF);
    cyc(1);
    chk("rerst_done_phystatus", 64'(phy_status), 64'h0);
    chk("rerst_done_busy", 64'(busy), 64'h0);
    cyc(3);
    chk("rerst_idle_busy", 64'(busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
